// File: rtl/axi_arbiter_if.sv
// One AXI4 link: AR/R plus single-beat AW/W/B, with IDs on the request channels.
// Latency: none, wires only.
// Backpressure: standard valid/ready on every channel; master drives requests, slave drives responses.
interface axi_arbiter_if;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic [3:0]  awid;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arlen, arsize, arburst, arid, arvalid, input arready,
    input rdata, rresp, rlast, rvalid, output rready,
    output awaddr, awsize, awid, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bresp, bvalid, output bready
  );

  modport slave (
    input araddr, arlen, arsize, arburst, arid, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready,
    input awaddr, awsize, awid, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/axi_arbiter.sv
// Shares one downstream AXI4 port between m0 (instruction fetch, reads) and m1 (LSU, reads + single-beat writes).
// Latency: one IDLE cycle registers the grant; the owner's channels then pass combinationally to/from s.
// Backpressure: non-owners see ready/valid 0 and keep requests pending; ARB_ROUND_ROBIN_EN swaps fixed m1 priority for round robin.
module axi_arbiter #(
  parameter logic [3:0] M0_ID = 4'd0,
  parameter logic [3:0] M1_ID = 4'd1
) (
  input  logic          i_clock,
  input  logic          i_reset,
  axi_arbiter_if.slave  m0,
  axi_arbiter_if.slave  m1,
  axi_arbiter_if.master s
);

  typedef enum logic [1:0] {IDLE, RD0, RD1, WR1} state_t;

  state_t state;
  state_t state_nxt;
  state_t m1_choice;
  logic   ar_done;
  logic   aw_done;
  logic   w_done;
  logic   m1_pend;
  logic   ar_hs;
  logic   aw_hs;
  logic   w_hs;
  logic   r_end;
  logic   b_end;
  logic   unused_inputs;

  // m1 read beats m1 write; either m1 request counts against m0
  assign m1_pend   = m1.arvalid | m1.awvalid;
  assign ar_hs     = s.arvalid & s.arready;
  assign aw_hs     = s.awvalid & s.awready;
  assign w_hs      = s.wvalid & s.wready;
  assign r_end     = s.rvalid & s.rready & s.rlast;
  assign b_end     = s.bvalid & s.bready;

  // IDs are substituted per master and m0 has no write path, so these inputs are intentionally ignored
  assign unused_inputs = ^{m0.arid, m0.awaddr, m0.awsize, m0.awid, m0.awvalid, m0.wdata,
                           m0.wstrb, m0.wlast, m0.wvalid, m0.bready, m1.arid, m1.awid, m1.wlast};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_m1;

  // remember which master won the latest grant; reset leaves m1 preferred
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      last_m1 <= 1'b0;
    end else if (state == IDLE && state_nxt != IDLE) begin
      last_m1 <= (state_nxt != RD0);
    end
  end
`endif

  // arbitrate in IDLE, release the port on the final R beat or the B handshake
  always_comb begin
    state_nxt = state;
    m1_choice = m1.arvalid ? RD1 : WR1;
    case (state)
      IDLE: begin
        if (m0.arvalid && m1_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_nxt = last_m1 ? RD0 : m1_choice;
`else
          state_nxt = m1_choice;
`endif
        end else if (m1_pend) begin
          state_nxt = m1_choice;
        end else if (m0.arvalid) begin
          state_nxt = RD0;
        end
      end
      RD0, RD1: if (r_end) state_nxt = IDLE;
      WR1:      if (b_end) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // state register; done flags stop a channel re-issuing once it has handshaken
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state   <= IDLE;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == IDLE) begin
        ar_done <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (ar_hs) ar_done <= 1'b1;
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
    end
  end

  // route the owner's channels to the shared port; everything else held idle
  always_comb begin
    s.araddr   = '0;
    s.arlen    = '0;
    s.arsize   = '0;
    s.arburst  = '0;
    s.arid     = '0;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    s.awaddr   = '0;
    s.awsize   = '0;
    s.awid     = '0;
    s.awvalid  = 1'b0;
    s.wdata    = '0;
    s.wstrb    = '0;
    s.wlast    = 1'b0;
    s.wvalid   = 1'b0;
    s.bready   = 1'b0;
    m0.arready = 1'b0;
    m0.rdata   = s.rdata;
    m0.rresp   = s.rresp;
    m0.rlast   = s.rlast;
    m0.rvalid  = 1'b0;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bresp   = 2'b00;
    m0.bvalid  = 1'b0;
    m1.arready = 1'b0;
    m1.rdata   = s.rdata;
    m1.rresp   = s.rresp;
    m1.rlast   = s.rlast;
    m1.rvalid  = 1'b0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bresp   = s.bresp;
    m1.bvalid  = 1'b0;
    if (!i_reset) begin
      case (state)
        RD0: begin
          s.araddr   = m0.araddr;
          s.arlen    = m0.arlen;
          s.arsize   = m0.arsize;
          s.arburst  = m0.arburst;
          s.arid     = M0_ID;
          s.arvalid  = m0.arvalid & ~ar_done;
          m0.arready = s.arready & ~ar_done;
          m0.rvalid  = s.rvalid;
          s.rready   = m0.rready;
        end
        RD1: begin
          s.araddr   = m1.araddr;
          s.arlen    = m1.arlen;
          s.arsize   = m1.arsize;
          s.arburst  = m1.arburst;
          s.arid     = M1_ID;
          s.arvalid  = m1.arvalid & ~ar_done;
          m1.arready = s.arready & ~ar_done;
          m1.rvalid  = s.rvalid;
          s.rready   = m1.rready;
        end
        WR1: begin
          s.awaddr   = m1.awaddr;
          s.awsize   = m1.awsize;
          s.awid     = M1_ID;
          s.awvalid  = m1.awvalid & ~aw_done;
          m1.awready = s.awready & ~aw_done;
          s.wdata    = m1.wdata;
          s.wstrb    = m1.wstrb;
          s.wvalid   = m1.wvalid & ~w_done;
          s.wlast    = m1.wvalid & ~w_done;
          m1.wready  = s.wready & ~w_done;
          m1.bvalid  = s.bvalid;
          s.bready   = m1.bready;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// Scoreboard bench for axi_arbiter: directed master requests, a reactive downstream slave,
// and a monitor that pops expected handshakes as they appear on the S port and master response channels.
module tb_axi_arbiter;
  localparam logic [3:0] M0_ID = 4'd5;
  localparam logic [3:0] M1_ID = 4'd9;
  localparam int EV_AR = 0, EV_AW = 1, EV_W = 2, EV_R0 = 3, EV_R1 = 4, EV_B1 = 5;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_arbiter_if m0_if ();
  axi_arbiter_if m1_if ();
  axi_arbiter_if s_if ();

  axi_arbiter #(.M0_ID(M0_ID), .M1_ID(M1_ID)) dut (
    .i_clock(clk), .i_reset(rst), .m0(m0_if), .m1(m1_if), .s(s_if)
  );

  ev_t   exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string kname[6] = '{"AR", "AW", "W", "R0", "R1", "B1"};
  logic [1:0] slave_rresp = 2'b00;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  function automatic void push(input int k, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    e.kind = k; e.a = a; e.b = b;
    exp_q.push_back(e);
  endfunction

  function automatic void push_read(input bit from_m1, input logic [31:0] addr, input logic [7:0] len,
                                    input logic [1:0] resp);
    push(EV_AR, addr, {20'd0, (from_m1 ? M1_ID : M0_ID), len});
    for (int i = 0; i <= int'(len); i++)
      push(from_m1 ? EV_R1 : EV_R0, addr + 32'(i), {29'd0, resp, (i == int'(len))});
  endfunction

  function automatic void observe(input int k, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_%s: got a=%h b=%h, required no handshake", kname[k], a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a !== a || e.b !== b) begin
        n_errors++;
        $display("FAIL sb_%s: got %s a=%h b=%h, required %s a=%h b=%h",
                 kname[e.kind], kname[k], a, b, kname[e.kind], e.a, e.b);
      end
    end
  endfunction

  // monitor: every handshake seen is matched against the scoreboard in a fixed per-cycle order
  always @(negedge clk) begin
    if (!rst) begin
      if (s_if.arvalid && s_if.arready) observe(EV_AR, s_if.araddr, {20'd0, s_if.arid, s_if.arlen});
      if (s_if.awvalid && s_if.awready) observe(EV_AW, s_if.awaddr, {28'd0, s_if.awid});
      if (s_if.wvalid && s_if.wready)   observe(EV_W, s_if.wdata, {27'd0, s_if.wlast, s_if.wstrb});
      if (m0_if.rvalid && m0_if.rready) observe(EV_R0, m0_if.rdata, {29'd0, m0_if.rresp, m0_if.rlast});
      if (m1_if.rvalid && m1_if.rready) observe(EV_R1, m1_if.rdata, {29'd0, m1_if.rresp, m1_if.rlast});
      if (m1_if.bvalid && m1_if.bready) observe(EV_B1, 32'd0, {30'd0, m1_if.bresp});
    end
  end

  // reactive downstream slave: R data = araddr + beat, B after both AW and W
  logic        sl_ar_hs, sl_r_hs, sl_aw_hs, sl_w_hs, sl_b_hs, sl_rst;
  logic [31:0] sl_base;
  logic [7:0]  sl_len, sl_beat;
  logic        sl_aw_seen, sl_w_seen;
  initial begin
    s_if.arready = 1'b1; s_if.rvalid = 1'b0; s_if.rdata = '0; s_if.rresp = '0; s_if.rlast = 1'b0;
    s_if.wready = 1'b1; s_if.bvalid = 1'b0; s_if.bresp = '0;
    sl_aw_seen = 1'b0; sl_w_seen = 1'b0; sl_base = '0; sl_len = '0; sl_beat = '0;
    forever begin
      @(negedge clk);
      sl_rst   = rst;
      sl_ar_hs = s_if.arvalid && s_if.arready;
      sl_r_hs  = s_if.rvalid && s_if.rready;
      sl_aw_hs = s_if.awvalid && s_if.awready;
      sl_w_hs  = s_if.wvalid && s_if.wready;
      sl_b_hs  = s_if.bvalid && s_if.bready;
      if (sl_ar_hs) begin sl_base = s_if.araddr; sl_len = s_if.arlen; end
      @(posedge clk); #1;
      if (sl_rst) begin
        s_if.rvalid = 1'b0; s_if.rlast = 1'b0; s_if.bvalid = 1'b0;
        sl_aw_seen = 1'b0; sl_w_seen = 1'b0;
      end else begin
        if (sl_r_hs) begin
          if (sl_beat == sl_len) begin
            s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
          end else begin
            sl_beat = sl_beat + 8'd1;
            s_if.rdata = sl_base + {24'd0, sl_beat}; s_if.rlast = (sl_beat == sl_len);
          end
        end
        if (sl_ar_hs) begin
          sl_beat = 8'd0; s_if.rvalid = 1'b1; s_if.rresp = slave_rresp;
          s_if.rdata = sl_base; s_if.rlast = (sl_len == 8'd0);
        end
        if (sl_aw_hs) sl_aw_seen = 1'b1;
        if (sl_w_hs)  sl_w_seen  = 1'b1;
        if (sl_b_hs) begin
          s_if.bvalid = 1'b0; sl_aw_seen = 1'b0; sl_w_seen = 1'b0;
        end else if (sl_aw_seen && sl_w_seen && !s_if.bvalid) begin
          s_if.bvalid = 1'b1; s_if.bresp = 2'b00;
        end
      end
    end
  end

  task automatic m0_read(input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    logic hs = 1'b0;
    m0_if.araddr = addr; m0_if.arlen = len; m0_if.arsize = 3'd2; m0_if.arburst = 2'b01; m0_if.arvalid = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk); hs = m0_if.arready; n++;
      @(posedge clk); #1;
    end
    m0_if.arvalid = 1'b0;
    check("m0_ar_handshake", {31'd0, hs}, 32'd1);
  endtask

  task automatic m1_read(input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    logic hs = 1'b0;
    m1_if.araddr = addr; m1_if.arlen = len; m1_if.arsize = 3'd2; m1_if.arburst = 2'b01; m1_if.arvalid = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk); hs = m1_if.arready; n++;
      @(posedge clk); #1;
    end
    m1_if.arvalid = 1'b0;
    check("m1_ar_handshake", {31'd0, hs}, 32'd1);
  endtask

  task automatic m1_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input bit w_first, input int aw_hold);
    int n = 0;
    logic aw_ok = 1'b0, w_ok = 1'b0;
    if (aw_hold > 0) s_if.awready = 1'b0;
    m1_if.awaddr = addr; m1_if.awsize = 3'd2; m1_if.wdata = data; m1_if.wstrb = strb; m1_if.wlast = 1'b1;
    m1_if.wvalid = 1'b1;
    if (w_first) begin @(posedge clk); #1; n++; end
    m1_if.awvalid = 1'b1;
    while (!(aw_ok && w_ok) && n < 200) begin
      @(negedge clk);
      if (m1_if.awvalid && m1_if.awready) aw_ok = 1'b1;
      if (m1_if.wvalid && m1_if.wready)   w_ok  = 1'b1;
      @(posedge clk); #1; n++;
      if (aw_ok) m1_if.awvalid = 1'b0;
      if (w_ok)  m1_if.wvalid  = 1'b0;
      if (n >= aw_hold) s_if.awready = 1'b1;
    end
    s_if.awready = 1'b1;
    check("m1_write_handshakes", {30'd0, aw_ok, w_ok}, 32'd3);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check(name, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic seen;
    m0_if.arvalid = 0; m0_if.araddr = '0; m0_if.arlen = '0; m0_if.arsize = '0; m0_if.arburst = '0; m0_if.arid = '0;
    m0_if.rready = 1; m0_if.awaddr = '0; m0_if.awsize = '0; m0_if.awid = '0; m0_if.awvalid = 0;
    m0_if.wdata = '0; m0_if.wstrb = '0; m0_if.wlast = 0; m0_if.wvalid = 0; m0_if.bready = 0;
    m1_if.arvalid = 0; m1_if.araddr = '0; m1_if.arlen = '0; m1_if.arsize = '0; m1_if.arburst = '0; m1_if.arid = '0;
    m1_if.rready = 1; m1_if.awaddr = '0; m1_if.awsize = '0; m1_if.awid = '0; m1_if.awvalid = 0;
    m1_if.wdata = '0; m1_if.wstrb = '0; m1_if.wlast = 0; m1_if.wvalid = 0; m1_if.bready = 1;
    s_if.awready = 1'b1;

    // reset: every downstream valid and every master-facing ready/valid low
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_valids", {29'd0, s_if.arvalid, s_if.awvalid, s_if.wvalid}, 32'd0);
    check("rst_m_readys", {28'd0, m0_if.arready, m1_if.arready, m1_if.awready, m1_if.wready}, 32'd0);
    check("rst_resp_valids", {27'd0, m0_if.rvalid, m1_if.rvalid, m1_if.bvalid, s_if.rready, s_if.bready}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // M0 read alone: one IDLE cycle, then grant with M0_ID and two beats to m0
    push_read(1'b0, 32'h3000_0000, 8'd1, 2'b00);
    fork
      m0_read(32'h3000_0000, 8'd1);
      begin
        @(negedge clk);
        check("idle_no_s_arvalid", {31'd0, s_if.arvalid}, 32'd0);
        check("idle_m0_arready", {31'd0, m0_if.arready}, 32'd0);
        @(negedge clk);
        check("rd0_grant_arvalid", {31'd0, s_if.arvalid}, 32'd1);
        check("rd0_arid", {28'd0, s_if.arid}, {28'd0, M0_ID});
      end
    join
    wait_drain("t_m0_alone_drained");

    // M0 and M1 together: M1 first, M0 blocked until M1 rlast, one IDLE cycle, then M0
    push_read(1'b1, 32'h1000_0000, 8'd1, 2'b00);
    push_read(1'b0, 32'h2000_0000, 8'd1, 2'b00);
    fork
      m0_read(32'h2000_0000, 8'd1);
      m1_read(32'h1000_0000, 8'd1);
      begin
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
          @(negedge clk); seen = m1_if.rvalid && m1_if.rready && m1_if.rlast; n++;
        end
        check("m1_last_seen", {31'd0, seen}, 32'd1);
        check("m0_blocked_arready", {31'd0, m0_if.arready}, 32'd0);
        @(negedge clk);
        check("b2b_idle_gap", {31'd0, s_if.arvalid}, 32'd0);
        @(negedge clk);
        check("b2b_grant_m0", {27'd0, s_if.arvalid, s_if.arid}, {27'd0, 1'b1, M0_ID});
      end
    join
    wait_drain("t_contend_drained");

    // sustained contention, two reads per master
`ifdef ARB_ROUND_ROBIN_EN
    push_read(1'b1, 32'h1000_0100, 8'd1, 2'b00);
    push_read(1'b0, 32'h2000_0100, 8'd1, 2'b00);
    push_read(1'b1, 32'h1000_0200, 8'd1, 2'b00);
    push_read(1'b0, 32'h2000_0200, 8'd1, 2'b00);
`else
    push_read(1'b1, 32'h1000_0100, 8'd1, 2'b00);
    push_read(1'b1, 32'h1000_0200, 8'd1, 2'b00);
    push_read(1'b0, 32'h2000_0100, 8'd1, 2'b00);
    push_read(1'b0, 32'h2000_0200, 8'd1, 2'b00);
`endif
    fork
      begin m1_read(32'h1000_0100, 8'd1); m1_read(32'h1000_0200, 8'd1); end
      begin m0_read(32'h2000_0100, 8'd1); m0_read(32'h2000_0200, 8'd1); end
    join
    wait_drain("t_sustained_drained");

    // M1 write, W offered before AW and AW stalled downstream: W beat with wlast, then AW, then B
    push(EV_W, 32'hDEAD_BEEF, {27'd0, 1'b1, 4'hF});
    push(EV_AW, 32'h8000_0010, {28'd0, M1_ID});
    push(EV_B1, 32'd0, 32'd0);
    fork
      m1_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 4);
      begin
        repeat (3) @(negedge clk);
        check("wr_wlast_with_wvalid", {30'd0, s_if.wvalid, s_if.wlast}, 32'd3);
        check("wr_aw_stalled", {31'd0, m1_if.awready}, 32'd0);
      end
    join
    wait_drain("t_write_drained");

    // M1 read and write pending together: read first, then AW and W in the same cycle
    push_read(1'b1, 32'h4000_0000, 8'd0, 2'b00);
    push(EV_AW, 32'h4000_0040, {28'd0, M1_ID});
    push(EV_W, 32'h1234_5678, {27'd0, 1'b1, 4'h3});
    push(EV_B1, 32'd0, 32'd0);
    fork
      m1_read(32'h4000_0000, 8'd0);
      m1_write(32'h4000_0040, 32'h1234_5678, 4'h3, 1'b0, 0);
    join
    wait_drain("t_rd_over_wr_drained");

    // error response forwarded unchanged
    slave_rresp = 2'b10;
    push_read(1'b0, 32'h3000_0040, 8'd0, 2'b10);
    m0_read(32'h3000_0040, 8'd0);
    wait_drain("t_rresp_drained");
    slave_rresp = 2'b00;

    // reset after the first of two beats: second beat never reaches m0
    push(EV_AR, 32'h3000_0080, {20'd0, M0_ID, 8'd1});
    push(EV_R0, 32'h3000_0080, {29'd0, 2'b00, 1'b0});
    fork
      m0_read(32'h3000_0080, 8'd1);
      begin
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
          @(negedge clk); seen = m0_if.rvalid && m0_if.rready; n++;
        end
        check("rst_first_beat_seen", {31'd0, seen}, 32'd1);
      end
    join
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_kills_valids", {29'd0, m0_if.rvalid, s_if.rready, s_if.arvalid}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_second_beat", {30'd0, m0_if.rvalid, s_if.rready}, 32'd0);
    check("rst_queue_consumed", 32'(exp_q.size()), 32'd0);

    // fresh grant after reset
    @(posedge clk); #1;
    push_read(1'b1, 32'h5000_0000, 8'd0, 2'b00);
    m1_read(32'h5000_0000, 8'd0);
    wait_drain("t_post_reset_drained");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/axi_arbiter.md
AXI_ARBITER -- requirements
Module: axi_arbiter

Interface
REQ-001 Parameter M0_ID, default 4'd0: ARID driven downstream for master 0 (instruction cache) reads.
REQ-002 Parameter M1_ID, default 4'd1: ARID/AWID driven downstream for master 1 (load/store unit) accesses.
REQ-003 i_clock  input  1  clock; all state changes on its rising edge.
REQ-004 i_reset  input  1  reset, synchronous, active-high.
REQ-005 M0 AR  i_m0_araddr[31:0], i_m0_arlen[7:0], i_m0_arsize[2:0], i_m0_arburst[1:0], i_m0_arvalid in; o_m0_arready out: instruction fetch read address channel.
REQ-006 M0 R  o_m0_rdata[31:0], o_m0_rresp[1:0], o_m0_rlast, o_m0_rvalid out; i_m0_rready in: instruction fetch read data channel.
REQ-007 M1 AR/R  same signal set as REQ-005/006 with m1 prefix: LSU read channels.
REQ-008 M1 AW/W/B  i_m1_awaddr[31:0], i_m1_awsize[2:0], i_m1_awvalid, i_m1_wdata[31:0], i_m1_wstrb[3:0], i_m1_wvalid, i_m1_bready in; o_m1_awready, o_m1_wready, o_m1_bresp[1:0], o_m1_bvalid out: LSU write channels, single-beat only.
REQ-009 S port  o_s_ar*/aw*/w* (incl. o_s_arid[3:0], o_s_awid[3:0], o_s_wlast) out, i_s_r*/b* in, matching widths above: single shared downstream AXI4 port.

Function
REQ-010 State machine SHALL have states IDLE, RD0, RD1, WR1; one transaction owns the downstream port at a time.
REQ-011 IDLE: pending requests are i_m0_arvalid, i_m1_arvalid, i_m1_awvalid; winner is registered into RD0/RD1/WR1 at the next edge (one-cycle arbitration latency); no downstream valid asserted in IDLE.
REQ-012 M1 read vs M1 write both pending: read wins.
REQ-013 M0 vs M1 (fixed priority): M1 wins.
REQ-014 Granted state: winner's AR (or AW and W) pass combinationally to S port; per-channel done flag set on handshake blocks re-issue of that channel until return to IDLE.
REQ-015 Non-granted masters: arready/awready/wready/rvalid/bvalid SHALL be 0; their requests held pending, not dropped.
REQ-016 RD0/RD1: S R channel routed to owner, i_s_rready = owner's rready; exit to IDLE on rvalid & rready & rlast.
REQ-017 WR1: o_s_wlast SHALL be 1 whenever o_s_wvalid; exit to IDLE on bvalid & bready; AW and W handshakes may complete in either order or same cycle.
REQ-018 o_s_arid/o_s_awid SHALL equal owner's M*_ID; response IDs not checked.
REQ-019 Back-to-back: earliest new grant registers in the cycle after the last beat (IDLE lasts one cycle).
REQ-020 Response beats with rresp/bresp != 0 SHALL be forwarded unchanged; no abort.

Reset
REQ-021 On i_reset: state IDLE, done flags 0, all out valids/readys 0, RR pointer = M0-last (M1 preferred).
REQ-022 Reset mid-transaction SHALL abandon it; no beats forwarded after reset deasserts until a new grant.

Configuration
REQ-023 Macro ARB_ROUND_ROBIN_EN defined: M0 vs M1 contention goes to master not granted most recently (pointer updated on every grant).
REQ-024 Macro undefined: fixed priority per REQ-013, no pointer register.

Verification
REQ-025 M0 read 0x3000_0000 arlen=1 alone -> grant RD0 next cycle, 2 beats to M0 only, IDLE after rlast, arid=M0_ID.
REQ-026 M0 and M1 arvalid same cycle, fixed priority -> M1 served first, M0 arready held 0 until M1 rlast, then M0 served.
REQ-027 Same as 026 with ARB_ROUND_ROBIN_EN, repeated 4 times -> grants alternate M1,M0,M1,M0...
REQ-028 M1 write 0x8000_0010 wdata 0xDEADBEEF wstrb 0xF, W before AW -> single W beat wlast=1, bvalid to M1, IDLE after bready.
REQ-029 i_reset asserted after first of 2 R beats -> all valids 0 next cycle, state IDLE, second beat not forwarded.
REQ-030 Slave rresp=2'b10 on M0 beat -> o_m0_rresp=2'b10, transaction completes normally.
